// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: RAW-hazard detection with stall, flush and memory-wait control plus perf counters.
module pipeline_hazard_controller #(
    parameter int MAX_STALL = 15,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic [3:0]       exe_dest,
    input  logic [3:0]       mem_dest,
    input  logic             exe_wb_en,
    input  logic             mem_wb_en,
    input  logic             exe_mem_read,
    input  logic             fwd_en,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             id_ex_freeze,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             hazard,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [7:0]       flush_count,
    output logic             deadlock
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, MEM_WAIT = 2'b10, FLUSH = 2'b11} state_t;
    localparam int SW = $clog2(MAX_STALL + 1);
    state_t cur, nxt;
    logic [SW-1:0] stall_cnt, stall_nxt;
    logic exe_hit, mem_hit, raw;
    assign state = cur;
    always_comb begin
        exe_hit = (src1 == exe_dest) || (two_src && src2 == exe_dest);
        mem_hit = (src1 == mem_dest) || (two_src && src2 == mem_dest);
        // with forwarding only a load in EXE cannot be bypassed in time
        raw = fwd_en ? (exe_mem_read && exe_wb_en && exe_hit)
                     : ((exe_wb_en && exe_hit) || (mem_wb_en && mem_hit));
        hazard = rst && raw && cur != FLUSH;
        pc_freeze = rst && (mem_busy || (!branch_taken && hazard));
        if_id_freeze = pc_freeze;
        id_ex_freeze = rst && mem_busy;
        if_id_flush = rst && !mem_busy && branch_taken;
        id_ex_flush = rst && !mem_busy && (branch_taken || hazard);
        nxt = mem_busy ? MEM_WAIT : branch_taken ? FLUSH : hazard ? STALL : RUN;
        stall_nxt = nxt != STALL ? '0 : cur != STALL ? SW'(1) :
                    stall_cnt == SW'(MAX_STALL) ? stall_cnt : stall_cnt + SW'(1);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur <= RUN;
            stall_cnt <= '0;
            stall_cycles <= '0;
            flush_count <= '0;
            deadlock <= 1'b0;
        end else begin
            cur <= nxt;
            stall_cnt <= stall_nxt;
            if (stall_nxt == SW'(MAX_STALL)) deadlock <= 1'b1;
            if (pc_freeze && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
            if (if_id_flush && !(&flush_count)) flush_count <= flush_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed spec cases plus random stimulus against a behavioural model.
module tb_pipeline_hazard_controller;
    localparam int CNT_W = 8;
    localparam int MAX_STALL = 15;
    logic clk = 0, rst = 0;
    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic two_src, exe_wb_en, mem_wb_en, exe_mem_read, fwd_en, branch_taken, mem_busy;
    logic pc_freeze, if_id_freeze, id_ex_freeze, if_id_flush, id_ex_flush, hazard, deadlock;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cycles;
    logic [7:0] flush_count;
    logic [5:0] dut_out;
    int checks = 0, passes = 0;
    int m_state = 0, m_run = 0, m_sc = 0, m_fc = 0;
    logic m_dead = 0;

    always #5 clk = ~clk;
    assign dut_out = {pc_freeze, if_id_freeze, id_ex_freeze, if_id_flush, id_ex_flush, hazard};

    pipeline_hazard_controller #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
        .exe_mem_read(exe_mem_read), .fwd_en(fwd_en), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .id_ex_freeze(id_ex_freeze),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .hazard(hazard), .state(state),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .deadlock(deadlock)
    );

    // registers written by in-flight instructions that ID cannot yet consume
    function automatic bit raw_m();
        bit reads[int];
        bit pending[int];
        reads[src1] = 1;
        if (two_src) reads[src2] = 1;
        if (fwd_en) begin
            if (exe_mem_read && exe_wb_en) pending[exe_dest] = 1;
        end else begin
            if (exe_wb_en) pending[exe_dest] = 1;
            if (mem_wb_en) pending[mem_dest] = 1;
        end
        foreach (reads[r]) if (pending.exists(r)) return 1;
        return 0;
    endfunction

    function automatic bit haz_m();
        return rst && raw_m() && m_state != 3;
    endfunction

    function automatic int act_m();
        return mem_busy ? 2 : branch_taken ? 3 : haz_m() ? 1 : 0;
    endfunction

    function automatic logic [5:0] out_m();
        logic [5:0] o;
        if (!rst) return 6'b0;
        case (act_m())
            2: o = 6'b111000;
            3: o = 6'b000110;
            1: o = 6'b110010;
            default: o = 6'b000000;
        endcase
        o[0] = haz_m();
        return o;
    endfunction

    task automatic tick();
        int a, nrun;
        logic [5:0] o;
        a = act_m();
        o = out_m();
        if (!rst) begin
            m_state = 0; m_run = 0; m_sc = 0; m_fc = 0; m_dead = 0;
        end else begin
            nrun = (a == 1) ? ((m_state == 1) ? m_run + 1 : 1) : 0;
            if (nrun >= MAX_STALL) m_dead = 1;
            if (o[5] && m_sc < (1 << CNT_W) - 1) m_sc++;
            if (a == 3 && m_fc < 255) m_fc++;
            m_state = a;
            m_run = nrun;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        rst = 1; src1 = 0; src2 = 0; two_src = 0; exe_dest = 0; mem_dest = 0;
        exe_wb_en = 0; mem_wb_en = 0; exe_mem_read = 0; fwd_en = 0; branch_taken = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        clear();
        rst = 0;
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        clear();
        rst = 0; src1 = 3; exe_dest = 3; exe_wb_en = 1; mem_busy = 1; branch_taken = 1;
        #2;
        checks++; if (dut_out !== 6'b0) $display("FAIL reset_outputs got %b want %b", dut_out, 6'b0); else passes++;
        tick();
        checks++; if ({state, deadlock} !== 3'b0) $display("FAIL reset_state got %b want 000", {state, deadlock}); else passes++;
        checks++; if (stall_cycles !== 0 || flush_count !== 0) $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cycles, flush_count); else passes++;
    endtask

    task automatic test_raw_stall();
        do_reset();
        src1 = 3; exe_dest = 3; exe_wb_en = 1;
        #2;
        checks++; if (dut_out !== 6'b110011) $display("FAIL raw_stall_ctrl got %b want %b", dut_out, 6'b110011); else passes++;
        tick();
        checks++; if (state !== 2'b01) $display("FAIL raw_stall_state got %b want 01", state); else passes++;
        exe_wb_en = 0; mem_dest = 3; mem_wb_en = 1; two_src = 1; src1 = 5; src2 = 3;
        #2;
        checks++; if (dut_out !== 6'b110011) $display("FAIL raw_src2_mem got %b want %b", dut_out, 6'b110011); else passes++;
        tick();
        clear();
        tick();
    endtask

    task automatic test_forwarding();
        do_reset();
        fwd_en = 1; src1 = 3; exe_dest = 3; exe_wb_en = 1; mem_dest = 3; mem_wb_en = 1;
        #2;
        checks++; if (dut_out !== 6'b0) $display("FAIL fwd_no_load got %b want %b", dut_out, 6'b0); else passes++;
        exe_mem_read = 1;
        #2;
        checks++; if (dut_out !== 6'b110011) $display("FAIL fwd_load got %b want %b", dut_out, 6'b110011); else passes++;
        tick();
        checks++; if (state !== 2'b01) $display("FAIL fwd_load_state got %b want 01", state); else passes++;
        exe_mem_read = 0; exe_dest = 7;
        #2;
        checks++; if (dut_out !== 6'b0) $display("FAIL fwd_release got %b want %b", dut_out, 6'b0); else passes++;
        tick();
        checks++; if (state !== 2'b00 || stall_cycles !== 1) $display("FAIL fwd_one_cycle got %b/%0d want 00/1", state, stall_cycles); else passes++;
    endtask

    task automatic test_branch();
        do_reset();
        src1 = 3; exe_dest = 3; exe_wb_en = 1; branch_taken = 1;
        #2;
        checks++; if (dut_out !== 6'b000111) $display("FAIL branch_ctrl got %b want %b", dut_out, 6'b000111); else passes++;
        tick();
        checks++; if (state !== 2'b11 || flush_count !== 1) $display("FAIL branch_state got %b/%0d want 11/1", state, flush_count); else passes++;
        branch_taken = 0;
        #2;
        checks++; if (dut_out !== 6'b0) $display("FAIL branch_bubble got %b want %b", dut_out, 6'b0); else passes++;
        tick();
        checks++; if (state !== 2'b00) $display("FAIL branch_after got %b want 00", state); else passes++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_busy = 1; branch_taken = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if (dut_out !== 6'b111000) $display("FAIL mem_wait_ctrl%0d got %b want %b", i, dut_out, 6'b111000); else passes++;
            tick();
        end
        checks++; if (state !== 2'b10 || stall_cycles !== 4 || flush_count !== 0) $display("FAIL mem_wait_state got %b/%0d/%0d want 10/4/0", state, stall_cycles, flush_count); else passes++;
        mem_busy = 0;
        #2;
        checks++; if (dut_out !== 6'b000110) $display("FAIL mem_wait_branch got %b want %b", dut_out, 6'b000110); else passes++;
        tick();
        checks++; if (state !== 2'b11 || flush_count !== 1) $display("FAIL mem_wait_flush got %b/%0d want 11/1", state, flush_count); else passes++;
        clear();
        tick();
    endtask

    task automatic test_deadlock();
        do_reset();
        src1 = 9; mem_dest = 9; mem_wb_en = 1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 14) begin
                checks++; if (deadlock !== 1'b0) $display("FAIL deadlock_early got %b want 0", deadlock); else passes++;
            end
        end
        checks++; if (deadlock !== 1'b1) $display("FAIL deadlock_set got %b want 1", deadlock); else passes++;
        clear();
        tick();
        tick();
        checks++; if (deadlock !== 1'b1 || state !== 2'b00) $display("FAIL deadlock_sticky got %b/%b want 1/00", deadlock, state); else passes++;
        rst = 0;
        tick();
        checks++; if (deadlock !== 1'b0) $display("FAIL deadlock_clear got %b want 0", deadlock); else passes++;
        rst = 1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        src1 = 4; exe_dest = 4; exe_wb_en = 1;
        tick();
        tick();
        rst = 0;
        #2;
        checks++; if (dut_out !== 6'b0) $display("FAIL mid_reset_outputs got %b want %b", dut_out, 6'b0); else passes++;
        tick();
        checks++; if (state !== 2'b00 || stall_cycles !== 0 || flush_count !== 0) $display("FAIL mid_reset_state got %b/%0d/%0d want 00/0/0", state, stall_cycles, flush_count); else passes++;
        rst = 1;
        for (int i = 0; i < 14; i++) tick();
        checks++; if (deadlock !== 1'b0 || state !== 2'b01) $display("FAIL mid_reset_restart got %b/%b want 0/01", deadlock, state); else passes++;
        clear();
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        branch_taken = 1;
        for (int i = 0; i < 260; i++) tick();
        checks++; if (flush_count !== 8'd255) $display("FAIL flush_sat got %0d want 255", flush_count); else passes++;
        mem_busy = 1;
        for (int i = 0; i < 260; i++) tick();
        checks++; if (stall_cycles !== 8'd255) $display("FAIL stall_sat got %0d want 255", stall_cycles); else passes++;
        clear();
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            src1 = 4'($urandom_range(0, 3)); src2 = 4'($urandom_range(0, 3));
            exe_dest = 4'($urandom_range(0, 3)); mem_dest = 4'($urandom_range(0, 3));
            two_src = 1'($urandom); exe_wb_en = 1'($urandom); mem_wb_en = 1'($urandom);
            exe_mem_read = 1'($urandom); fwd_en = 1'($urandom);
            branch_taken = ($urandom_range(0, 7) == 0);
            mem_busy = ($urandom_range(0, 5) == 0);
            #2;
            checks++;
            if (dut_out !== out_m() || (if_id_freeze & if_id_flush) || (id_ex_freeze & id_ex_flush)) begin
                if (bad++ < 10) $display("FAIL rand_ctrl cycle %0d got %b want %b", i, dut_out, out_m());
            end else passes++;
            tick();
            checks++;
            if (state !== 2'(m_state) || stall_cycles !== CNT_W'(m_sc) || flush_count !== 8'(m_fc) || deadlock !== m_dead) begin
                if (bad++ < 10) $display("FAIL rand_state cycle %0d got %b/%0d/%0d/%b want %0d/%0d/%0d/%b",
                    i, state, stall_cycles, flush_count, deadlock, m_state, m_sc, m_fc, m_dead);
            end else passes++;
        end
    endtask

    initial begin
        clear();
        rst = 0;
        #1;
        test_reset();
        test_raw_stall();
        test_forwarding();
        test_branch();
        test_mem_wait();
        test_deadlock();
        test_reset_mid();
        test_saturation();
        do_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
